// File: rtl/qr_array_sched.sv
// Row sequencer for the Givens-rotation QR systolic array: skewed per-column launches,
// rotate enables and array clear. Optional stall counter under QR_SCHED_STALL_CNT_EN.
module qr_array_sched #(
    parameter int N_COLS     = 4,
    parameter int N_ROWS     = 8,
    parameter int DATA_WIDTH = 20,
    parameter int ROT_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [DATA_WIDTH*N_COLS-1:0]   in_data_i,
    output logic [DATA_WIDTH*N_COLS-1:0]   feed_data_o,
    output logic [N_COLS-1:0]              feed_valid_o,
    output logic [N_COLS-1:0]              rotates_o,
    output logic                           clr_o,
    output logic                           busy_o,
    output logic                           done_o,
`ifdef QR_SCHED_STALL_CNT_EN
    output logic [15:0]                    stall_cnt_o,
`endif
    output logic [$clog2(N_ROWS+1)-1:0]    row_cnt_o
);

    localparam int SW = $clog2(ROT_CYCLES);
    localparam int CW = $clog2(N_ROWS + 1);
    localparam int RW = DATA_WIDTH * N_COLS;
    localparam logic [SW-1:0] SLOT_LAST = SW'(ROT_CYCLES - 1);
    localparam logic [CW-1:0] ROWS_MAX  = CW'(N_ROWS);
    localparam logic [CW-1:0] ROWS_LAST = CW'(N_ROWS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [CW-1:0]     row_cnt_q, row_cnt_d;
    logic [N_COLS-1:0] launch_q, launch_d;
    logic [N_COLS-1:0] rot_q, rot_d;
    logic [SW-1:0]     rcnt_q [N_COLS];
    logic [SW-1:0]     rcnt_d [N_COLS];
    logic [RW-1:0]     row_q  [N_COLS];
    logic [RW-1:0]     row_d  [N_COLS];
    logic              accept;

    always_comb begin
        in_ready_o = (state_q == S_FEED) && (slot_q == '0) && (row_cnt_q < ROWS_MAX);
        accept     = in_ready_o && in_valid_i;
    end

    // Skew pipeline: column j launches the cycle after column j-1 finishes its rotation
    // pass, carrying the row forward so later columns still see it after new rows arrive.
    always_comb begin
        launch_d = '0;
        rot_d    = rot_q;
        for (int j = 0; j < N_COLS; j++) begin
            rcnt_d[j] = rcnt_q[j];
            row_d[j]  = row_q[j];
        end
        if (state_q == S_CLEAR) begin
            rot_d = '0;
            for (int j = 0; j < N_COLS; j++) begin
                rcnt_d[j] = '0;
                row_d[j]  = '0;
            end
        end else begin
            launch_d[0] = accept;
            for (int j = 1; j < N_COLS; j++) begin
                launch_d[j] = rot_q[j-1] && (rcnt_q[j-1] == SLOT_LAST);
            end
            for (int j = 0; j < N_COLS; j++) begin
                if (launch_d[j]) begin
                    rot_d[j]  = 1'b1;
                    rcnt_d[j] = '0;
                end else if (rot_q[j]) begin
                    if (rcnt_q[j] == SLOT_LAST) begin
                        rot_d[j] = 1'b0;
                    end
                    rcnt_d[j] = rcnt_q[j] + 1'b1;
                end
            end
            if (accept) begin
                row_d[0] = in_data_i;
            end
            for (int j = 1; j < N_COLS; j++) begin
                if (launch_d[j]) begin
                    row_d[j] = row_q[j-1];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                slot_d    = '0;
                row_cnt_d = '0;
                state_d   = S_FEED;
            end
            S_FEED: begin
                slot_d = slot_q + 1'b1;
                if (accept) begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == ROWS_LAST) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Looking at next-cycle enables lets DONE follow the last rotate cycle directly.
                if ((rot_d == '0) && (launch_d == '0)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            slot_q    <= '0;
            row_cnt_q <= '0;
            launch_q  <= '0;
            rot_q     <= '0;
            for (int j = 0; j < N_COLS; j++) begin
                rcnt_q[j] <= '0;
                row_q[j]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            row_cnt_q <= row_cnt_d;
            launch_q  <= launch_d;
            rot_q     <= rot_d;
            for (int j = 0; j < N_COLS; j++) begin
                rcnt_q[j] <= rcnt_d[j];
                row_q[j]  <= row_d[j];
            end
        end
    end

`ifdef QR_SCHED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_CLEAR) begin
            stall_d = '0;
        end else if (in_ready_o && !in_valid_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`endif

    always_comb begin
        feed_data_o = '0;
        for (int j = 0; j < N_COLS; j++) begin
            feed_data_o[j*DATA_WIDTH +: DATA_WIDTH] = row_q[j][j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign feed_valid_o = launch_q;
    assign rotates_o    = rot_q;
    assign clr_o        = (state_q == S_CLEAR);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign row_cnt_o    = row_cnt_q;

endmodule

// File: tb/tb_qr_array_sched.sv
// Bench for qr_array_sched: per-cycle comparison against a timing-rule model built from
// the list of accepted rows (accept cycle + data).
module tb_qr_array_sched;
    localparam int NC = 4;
    localparam int NR = 8;
    localparam int W  = 20;
    localparam int R  = 4;
    localparam int CW = $clog2(NR + 1);

    logic            clk = 1'b0;
    logic            rst_n, start_i, in_valid_i, in_ready_o;
    logic [NC*W-1:0] in_data_i, feed_data_o;
    logic [NC-1:0]   feed_valid_o, rotates_o;
    logic            clr_o, busy_o, done_o;
    logic [CW-1:0]   row_cnt_o;
`ifdef QR_SCHED_STALL_CNT_EN
    logic [15:0]     stall_cnt_o;
`endif

    qr_array_sched #(.N_COLS(NC), .N_ROWS(NR), .DATA_WIDTH(W), .ROT_CYCLES(R)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_data_i(in_data_i), .feed_data_o(feed_data_o),
        .feed_valid_o(feed_valid_o), .rotates_o(rotates_o), .clr_o(clr_o),
        .busy_o(busy_o), .done_o(done_o),
`ifdef QR_SCHED_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .row_cnt_o(row_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Model state: the current matrix is fully described by its start cycle and accepts.
    bit              started;
    int              st_cyc;
    int              acc_t[$];
    logic [NC*W-1:0] acc_d[$];
    int              stall_t[$];
    logic [NC*W-1:0] old_fd;
    int              old_rc, old_stall;
    int              obs_done, obs_clr, obs_fv3, n_clr, last_s0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        started = 1'b0;
        st_cyc  = -100;
        acc_t.delete();
        acc_d.delete();
        stall_t.delete();
        old_fd    = '0;
        old_rc    = 0;
        old_stall = 0;
    endtask

    function automatic int done_cyc();
        return (acc_t.size() == NR) ? acc_t[NR-1] + NC*R + 1 : -1;
    endfunction

    function automatic logic [NC-1:0] e_fv(input int c);
        logic [NC-1:0] e = '0;
        foreach (acc_t[i])
            for (int j = 0; j < NC; j++)
                if (acc_t[i] + 1 + j*R == c) e[j] = 1'b1;
        return e;
    endfunction

    function automatic logic [NC-1:0] e_rot(input int c);
        logic [NC-1:0] e = '0;
        foreach (acc_t[i])
            for (int j = 0; j < NC; j++)
                if (c >= acc_t[i] + 1 + j*R && c <= acc_t[i] + (j+1)*R) e[j] = 1'b1;
        return e;
    endfunction

    function automatic logic [NC*W-1:0] e_fd(input int c);
        logic [NC*W-1:0] e = '0;
        for (int j = 0; j < NC; j++) begin
            bit found = 1'b0;
            foreach (acc_t[i])
                if (acc_t[i] + 1 + j*R <= c) begin
                    e[j*W +: W] = acc_d[i][j*W +: W];
                    found = 1'b1;
                end
            if (!found && started && c <= st_cyc + 1) e[j*W +: W] = old_fd[j*W +: W];
        end
        return e;
    endfunction

    function automatic bit e_ready(input int c);
        return started && (c >= st_cyc + 2) && (acc_t.size() < NR) && (((c - st_cyc - 2) % R) == 0);
    endfunction

    function automatic bit e_busy(input int c);
        int d = done_cyc();
        return started && (c >= st_cyc + 1) && (d < 0 || c <= d);
    endfunction

    function automatic int e_rc(input int c);
        int n = 0;
        if (!started) return 0;
        if (c <= st_cyc + 1) return old_rc;
        foreach (acc_t[i]) if (acc_t[i] < c) n++;
        return n;
    endfunction

    function automatic int e_stall(input int c);
        int n = 0;
        if (!started) return 0;
        if (c <= st_cyc + 1) return old_stall;
        foreach (stall_t[i]) if (stall_t[i] < c) n++;
        return n;
    endfunction

    // Check every output for the current cycle, update the model, advance one clock.
    task automatic run_cycle();
        logic [NC*W-1:0] efd;
        bit              er, eb;
        int              erc, est;
        @(negedge clk);
        efd = e_fd(cyc);
        er  = e_ready(cyc);
        eb  = e_busy(cyc);
        erc = e_rc(cyc);
        est = e_stall(cyc);
        chk("in_ready",   in_ready_o,   er);
        chk("feed_data",  feed_data_o,  efd);
        chk("feed_valid", feed_valid_o, e_fv(cyc));
        chk("rotates",    rotates_o,    e_rot(cyc));
        chk("clr",        clr_o,        started && (cyc == st_cyc + 1));
        chk("busy",       busy_o,       eb);
        chk("done",       done_o,       cyc == done_cyc());
        chk("row_cnt",    row_cnt_o,    erc);
`ifdef QR_SCHED_STALL_CNT_EN
        chk("stall_cnt",  stall_cnt_o,  est);
`endif
        if (done_o) obs_done = cyc;
        if (clr_o) begin
            obs_clr = cyc;
            n_clr++;
        end
        if (feed_valid_o[NC-1] && obs_fv3 < 0) obs_fv3 = cyc;
        if (er && in_valid_i) begin
            acc_t.push_back(cyc);
            acc_d.push_back(in_data_i);
        end
        if (er && !in_valid_i) stall_t.push_back(cyc);
        if (start_i && !eb) begin
            old_fd    = efd;
            old_rc    = erc;
            old_stall = est;
            started   = 1'b1;
            st_cyc    = cyc;
            acc_t.delete();
            acc_d.delete();
            stall_t.delete();
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready",   in_ready_o,   1'b0);
        chk("rst_data",    feed_data_o,  '0);
        chk("rst_valid",   feed_valid_o, '0);
        chk("rst_rotates", rotates_o,    '0);
        chk("rst_busy",    busy_o,       1'b0);
        chk("rst_row_cnt", row_cnt_o,    '0);
        model_clear();
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        run_cycle();
        run_cycle();
        rst_n = 1'b1;
    endtask

    // mode 0: sequential rows, 1: random valid/data, 2: negative elements on even columns
    task automatic run_matrix(input int mode, input int drop_rel, input int xstart_rel, input int rst_rel);
        int  s0, rel, idx;
        bit  fin;
        logic signed [W-1:0] neg;
        neg = -20'sd512;
        s0 = cyc;
        last_s0 = cyc;
        fin = 1'b0;
        obs_done = -1;
        obs_clr  = -1;
        obs_fv3  = -1;
        n_clr    = 0;
        for (int k = 0; k < 300; k++) begin
            rel = cyc - s0;
            if (rel == rst_rel) begin
                mid_reset();
                break;
            end
            start_i = (rel == 0) || (rel == xstart_rel);
            idx = acc_t.size() + 1;
            if (mode == 1) in_valid_i = ($urandom_range(0, 3) != 0);
            else           in_valid_i = (rel != drop_rel);
            for (int j = 0; j < NC; j++) begin
                if (mode == 1)                   in_data_i[j*W +: W] = W'($urandom);
                else if (mode == 2 && j % 2 == 0) in_data_i[j*W +: W] = neg;
                else                              in_data_i[j*W +: W] = W'(idx);
            end
            run_cycle();
            if (done_cyc() >= 0 && cyc > done_cyc() + 1) begin
                fin = 1'b1;
                break;
            end
        end
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        if (rst_rel < 0) chk("matrix_finished", fin, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        model_clear();
        @(posedge clk);
        #1;
        cyc = 0;
        run_cycle();
        run_cycle();
        rst_n = 1'b1;
        in_valid_i = 1'b1;
        run_cycle();
        run_cycle();
        in_valid_i = 1'b0;
        run_cycle();

        run_matrix(0, -1, -1, -1);
        chk("b2b_clr_rel",  obs_clr - last_s0,  1);
        chk("b2b_fv3_rel",  obs_fv3 - last_s0,  15);
        chk("b2b_done_rel", obs_done - last_s0, 47);
        chk("b2b_row_cnt",  row_cnt_o,          NR);

        run_matrix(0, 10, -1, -1);
        chk("bubble_done_rel", obs_done - last_s0, 51);
`ifdef QR_SCHED_STALL_CNT_EN
        chk("bubble_stall", stall_cnt_o, 1);
`endif

        run_matrix(2, -1, 12, -1);
        chk("ignored_start_clr_count", n_clr, 1);
        chk("neg_done_rel", obs_done - last_s0, 47);

        run_matrix(1, -1, -1, 20);
        run_matrix(0, -1, -1, -1);
        chk("after_reset_done_rel", obs_done - last_s0, 47);

        for (int m = 0; m < 4; m++) begin
            run_matrix(1, -1, int'($urandom_range(3, 30)), -1);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
